// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the mux-select arbiter.
// The master side drives the requests; the slave side (the arbiter) answers
// with the one-hot grant, the mux select pair x/y and the active flag.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       x;
    logic       y;
    logic       active;

    modport master (
        output req,
        input  gnt,
        input  x,
        input  y,
        input  active
    );

    modport slave (
        input  req,
        output gnt,
        output x,
        output y,
        output active
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux between requesters a..d.
// A grant is held while its owner keeps requesting, until HOLD_MAX granted
// cycles have elapsed and someone else is waiting; the owner is then
// preempted. Owner release hands over at the same edge (no idle bubble).
// x/y keep the last owner's index while idle, so consumers qualify with active.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             active_q, active_d;

    // Decisions produced by the next-state logic
    logic             grant_now;
    logic             go_idle;
    logic [3:0]       elig;
    logic [3:0]       others;
    logic [1:0]       cand;

    // First set bit of elig scanning last+1, last+2, last+3, then last.
    // Scanning from the far end down lets the nearest index win.
    function automatic logic [1:0] rr_pick(input logic [3:0] e, input logic [1:0] l);
        logic [1:0] idx;
        rr_pick = l;
        for (int k = 3; k >= 1; k--) begin
            idx = l + 2'(k);
            if (e[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // State register: IDLE after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: pick between new grant, release to idle, or hold
    always_comb begin
        state_d   = state_q;
        grant_now = 1'b0;
        go_idle   = 1'b0;
        elig      = bus.req;
        others    = bus.req & ~onehot(last_q);
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_now = 1'b1;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[last_q]) begin
                    if (|others) begin
                        grant_now = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_d = IDLE;
                    end
                end else if ((cnt_q == HOLD_C) && (|others)) begin
                    grant_now = 1'b1;
                    elig      = others;
                end
            end
            default: state_d = IDLE;
        endcase
        cand = rr_pick(elig, last_q);
    end

    // Output/datapath next values: grant loads owner, hold counts, idle clears
    always_comb begin
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        active_d = active_q;
        if (grant_now) begin
            last_d   = cand;
            cnt_d    = ONE_C;
            gnt_d    = onehot(cand);
            sel_d    = cand;
            active_d = 1'b1;
        end else if (go_idle) begin
            cnt_d    = '0;
            gnt_d    = 4'b0000;
            active_d = 1'b0;
        end else if ((state_q == GRANT) && (cnt_q != HOLD_C)) begin
            cnt_d    = cnt_q + ONE_C;
        end
    end

    // Registered outputs and arbitration pointer; last=3 gives a top priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 2'd3;
            cnt_q    <= '0;
            gnt_q    <= 4'b0000;
            sel_q    <= 2'd0;
            active_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            active_q <= active_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.x      = sel_q[1];
    assign bus.y      = sel_q[0];
    assign bus.active = active_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter with HOLD_MAX=4: directed scenarios followed by
// random request traffic, checked by a scoreboard fed from a reference model.
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;

    localparam int HOLD = 4;

    logic clk;
    logic rst_n;
    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       active;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: owner index (-1 when idle), granted-cycle count,
    // round-robin pointer and the last select value shown on x/y.
    int m_owner;
    int m_held;
    int m_last;
    int m_sel;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req_v);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
        int i;
        for (int k = 1; k <= 4; k++) begin
            i = (m_last + k) % 4;
            if (r[i]) return i;
        end
        return m_last;
    endfunction

    task automatic take(input int i);
        m_owner = i;
        m_last  = i;
        m_sel   = i;
        m_held  = 1;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_sel   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] oth;
        if (m_owner < 0) begin
            if (r != 4'b0000) take(pick(r));
        end else begin
            oth = r & ~(4'b0001 << m_owner);
            if (!r[m_owner]) begin
                if (oth != 4'b0000) take(pick(r));
                else m_owner = -1;
            end else if (m_held >= HOLD && oth != 4'b0000) begin
                take(pick(oth));
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply one cycle of requests and queue what the next edge must produce
    task automatic drive(input logic [3:0] r);
        exp_t e;
        @(negedge clk);
        bus.req = r;
        model_step(r);
        e.gnt    = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        e.sel    = 2'(m_sel);
        e.active = (m_owner >= 0);
        sb_q.push_back(e);
    endtask

    // Mid-cycle asynchronous reset with all requests high
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        bus.req = 4'b1111;
        rst_n   = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt",    bus.gnt, 4'b0000);
        chk("rst_xy",     {2'b00, bus.x, bus.y}, 4'b0000);
        chk("rst_active", {3'b000, bus.active}, 4'b0000);
        @(posedge clk);
        #1;
        chk("rst_hold_gnt",    bus.gnt, 4'b0000);
        chk("rst_hold_active", {3'b000, bus.active}, 4'b0000);
        @(negedge clk);
        bus.req = 4'b0000;
        rst_n   = 1'b1;
    endtask

    // Monitor: each edge with an outstanding expectation is compared
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("gnt",    bus.gnt, e.gnt);
                chk("xy",     {2'b00, bus.x, bus.y}, {2'b00, e.sel});
                chk("active", {3'b000, bus.active}, {3'b000, e.active});
            end
        end
    end

    // Stimulus
    initial begin
        logic [3:0] r;
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        model_reset();
        #1;
        chk("por_gnt",    bus.gnt, 4'b0000);
        chk("por_xy",     {2'b00, bus.x, bus.y}, 4'b0000);
        chk("por_active", {3'b000, bus.active}, 4'b0000);
        #13;
        rst_n = 1'b1;

        // Single request then drop
        drive(4'b0001);
        drive(4'b0000);
        drive(4'b0000);

        // Rotation under constant full request
        pulse_reset();
        repeat (18) drive(4'b1111);

        // Hand-over without bubble
        pulse_reset();
        drive(4'b0101);
        drive(4'b0101);
        drive(4'b0100);
        drive(4'b0100);

        // Sole owner saturation, then a late competitor preempts
        pulse_reset();
        repeat (12) drive(4'b1000);
        drive(4'b1010);
        drive(4'b1010);

        // Reset mid-operation restarts scanning from index 0
        pulse_reset();
        drive(4'b0100);
        drive(4'b0100);
        pulse_reset();
        drive(4'b1010);
        drive(4'b1010);

        // Random traffic, requests held for a few cycles at a time
        r = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            drive(r);
            if (n == 200) pulse_reset();
        end
        drive(4'b0000);

        // Drain scoreboard within a bounded number of cycles
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
